// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and width defaults for the cache refill controller.
package cache_ctrl_pkg;

  localparam int ADDR_SIZE_D = 32;
  localparam int DATA_SIZE_D = 32;
  localparam int CNT_SIZE_D  = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_RD   = 3'd2,
    FILL     = 3'd3,
    WR_CACHE = 3'd4,
    MEM_WR   = 3'd5,
    RESP     = 3'd6
  } state_t;

  function automatic logic in_mem_phase(input state_t s);
    return (s == MEM_RD) || (s == MEM_WR);
  endfunction

  function automatic logic in_cache_write(input state_t s);
    return (s == FILL) || (s == WR_CACHE);
  endfunction

endpackage

// File: rtl/cache_refill_controller_sat_counter.sv
// Saturating up-counter used for the hit/miss statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (inc && count != MAX) count <= count + ONE;
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Sequences a one-word-block cache and a slow memory for a single requester:
// read hit, read miss with refill, and write-through/write-allocate.
module cache_refill_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_D,
  parameter int DATA_SIZE = DATA_SIZE_D,
  parameter int CNT_SIZE  = CNT_SIZE_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [DATA_SIZE-1:0] cpu_wdata,
  output logic [DATA_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic [ADDR_SIZE-1:0] cache_addr,
  output logic                 cache_we,
  output logic [DATA_SIZE-1:0] cache_wdata,
  input  logic [DATA_SIZE-1:0] cache_rdata,
  input  logic                 cache_hit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic [CNT_SIZE-1:0]  hit_count,
  output logic [CNT_SIZE-1:0]  miss_count
);

  state_t               state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic                 we_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [DATA_SIZE-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          we_q    <= cpu_we;
          wdata_q <= cpu_wdata;
          state   <= cpu_we ? WR_CACHE : LOOKUP;
        end
        LOOKUP: if (cache_hit) begin
          rdata_q <= cache_rdata;
          state   <= RESP;
        end else begin
          state   <= MEM_RD;
        end
        MEM_RD: if (mem_ack) begin
          rdata_q <= mem_rdata;
          state   <= FILL;
        end
        FILL:     state <= RESP;
        WR_CACHE: state <= MEM_WR;
        MEM_WR:   if (mem_ack) state <= RESP;
        RESP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so async reset drops them at once.
  assign cpu_ready   = (state == RESP);
  assign cpu_rdata   = rdata_q;
  assign cache_addr  = addr_q;
  assign cache_we    = in_cache_write(state);
  assign cache_wdata = (state == FILL) ? rdata_q : wdata_q;
  assign mem_req     = in_mem_phase(state);
  assign mem_we      = (state == MEM_WR);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  logic hit_inc, miss_inc;
  assign hit_inc  = (state == LOOKUP) && !we_q &&  cache_hit;
  assign miss_inc = (state == LOOKUP) && !we_q && !cache_hit;

  sat_counter #(.WIDTH(CNT_SIZE)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_SIZE)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule
